// File: rtl/mips_stage_fetch_queue_pkg.sv
// Shared pipeline types for the MIPS core: clock/reset bundle, word type and
// the fetch-to-decode bundle carried between the fetch queue and decode.
package mips_stage_fetch_queue_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef struct packed {
    logic clk;
    logic rst_n;
  } Data_Control_Control_T;

  typedef struct packed {
    logic  valid;
    word_t instr;
    word_t pc;
  } fetch_decode_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;

  localparam word_t PC_STEP = 32'd4;

  function automatic word_t next_pc(input word_t pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/mips_fetch_fifo.sv
// Synchronous FIFO with asynchronous active-low reset and a flush that wins
// over push and pop; exposes occupancy and the head entry.
module mips_fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify push/pop against occupancy; a push into a full FIFO is allowed only alongside a pop.
  always_comb begin
    do_pop_s  = 1'b0;
    do_push_s = 1'b0;
    if (!flush) begin
      do_pop_s  = pop && (count_r != '0);
      do_push_s = push && ((count_r != CW'(DEPTH)) || do_pop_s);
    end else begin
      do_pop_s  = 1'b0;
      do_push_s = 1'b0;
    end
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_r[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/mips_stage_fetch_queue.sv
// Instruction fetch queue: credit-limited sequential fetch into a PC-tagged
// buffer, with redirect flushing the buffer and dropping in-flight responses.
module mips_stage_fetch_queue
  import mips_stage_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter word_t       RESET_PC = 32'h0
) (
  input  Data_Control_Control_T ctrl,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [31:0]           imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [31:0]           imem_rsp_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_instr,
  output logic [31:0]           out_pc
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic          clk_s;
  logic          rst_n_s;
  word_t         fetch_pc_r;
  word_t         rsp_pc_r;
  logic [CW-1:0] outstanding_r;
  logic [CW-1:0] drop_r;
  logic [CW-1:0] count_s;
  logic [CW:0]   inflight_s;
  logic          req_fire_s;
  logic          push_s;
  logic          pop_s;
  fetch_entry_t  push_entry_s;
  fetch_entry_t  head_s;
  fetch_decode_t dec_s;

  assign clk_s   = ctrl.clk;
  assign rst_n_s = ctrl.rst_n;

  // Credit check counts buffered plus kept in-flight words; the saturation
  // guard keeps outstanding from wrapping when dropped requests pile up.
  always_comb begin
    inflight_s     = {1'b0, count_s} + {1'b0, outstanding_r} - {1'b0, drop_r};
    imem_req_valid = rst_n_s && !redirect_valid
                     && (inflight_s < (CW+1)'(DEPTH))
                     && (outstanding_r != CNT_MAX);
    req_fire_s     = imem_req_valid && imem_req_ready;
    push_s         = imem_rsp_valid && !redirect_valid && (drop_r == '0);
    pop_s          = dec_s.valid && out_ready && !redirect_valid;
    push_entry_s   = '{pc: rsp_pc_r, instr: imem_rsp_data};
  end

  // Fetch/response PCs and the in-flight and drop counters.
  always_ff @(posedge clk_s or negedge rst_n_s) begin
    if (!rst_n_s) begin
      fetch_pc_r    <= RESET_PC;
      rsp_pc_r      <= RESET_PC;
      outstanding_r <= '0;
      drop_r        <= '0;
    end else begin
      outstanding_r <= outstanding_r + CW'(req_fire_s) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        fetch_pc_r <= redirect_pc;
        rsp_pc_r   <= redirect_pc;
        drop_r     <= outstanding_r - CW'(imem_rsp_valid);
      end else begin
        if (req_fire_s) fetch_pc_r <= next_pc(fetch_pc_r);
        if (imem_rsp_valid) begin
          if (drop_r != '0) drop_r <= drop_r - CW'(1);
          else              rsp_pc_r <= next_pc(rsp_pc_r);
        end
      end
    end
  end

  mips_fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk       (clk_s),
    .rst_n     (rst_n_s),
    .flush     (redirect_valid),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .count     (count_s),
    .head      (head_s)
  );

  assign dec_s         = '{valid: (count_s != '0), instr: head_s.instr, pc: head_s.pc};
  assign imem_req_addr = fetch_pc_r;
  assign out_valid     = dec_s.valid;
  assign out_instr     = dec_s.instr;
  assign out_pc        = dec_s.pc;

endmodule

// File: tb/tb_mips_stage_fetch_queue.sv
// Self-checking bench: in-order variable-latency memory model plus a stream
// model (sequential PCs from the last redirect target, instr = memory word).
module tb_mips_stage_fetch_queue;
  import mips_stage_fetch_queue_pkg::*;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  Data_Control_Control_T ctrl;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  assign ctrl.clk   = clk;
  assign ctrl.rst_n = rst_n;

  mips_stage_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .ctrl           (ctrl),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // memory model and stream model state
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          cyc;
  int          lat;
  int          ready_mode;   // 0: always ready, 1: random
  int          oready_mode;  // 0: low, 1: high, 2: random
  logic [31:0] exp_req;
  logic [31:0] exp_out;
  logic [31:0] req_got[$];
  logic [31:0] req_exp[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_instr[$];
  logic [31:0] pop_exp[$];
  int          kept;
  int          kept_max;
  int          redir_req_cnt;
  logic        s_req_valid;
  logic        s_out_valid;
  logic [31:0] s_req_addr;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h0019_660D) + 32'h3C6E_F35F;
  endfunction

  task automatic drive_next();
    imem_req_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    if (oready_mode == 0)      out_ready = 1'b0;
    else if (oready_mode == 1) out_ready = 1'b1;
    else                       out_ready = 1'($urandom_range(0, 1));
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memf(mq_addr[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom();
    end
  endtask

  // One clock: sample at negedge, update models after posedge, drive next inputs.
  task automatic step();
    logic rq, rsp, pop, redir;
    logic [31:0] ra, tgt, opc, oin, tmp_a;
    int tmp_d;
    @(negedge clk);
    rq    = imem_req_valid && imem_req_ready;
    ra    = imem_req_addr;
    rsp   = imem_rsp_valid;
    pop   = out_valid && out_ready;
    opc   = out_pc;
    oin   = out_instr;
    redir = redirect_valid;
    tgt   = redirect_pc;
    s_req_valid = imem_req_valid;
    s_req_addr  = ra;
    s_out_valid = out_valid;
    if (redir && imem_req_valid) redir_req_cnt++;
    @(posedge clk);
    #1;
    if (rq) begin
      mq_addr.push_back(ra);
      mq_due.push_back(cyc + lat);
      req_got.push_back(ra);
      req_exp.push_back(exp_req);
      exp_req = exp_req + 32'd4;
    end
    if (rsp && mq_addr.size() > 0) begin
      tmp_a = mq_addr.pop_front();
      tmp_d = mq_due.pop_front();
    end
    if (redir) begin
      exp_req = tgt;
      exp_out = tgt;
      kept    = 0;
    end else begin
      if (pop) begin
        pop_pc.push_back(opc);
        pop_instr.push_back(oin);
        pop_exp.push_back(exp_out);
        exp_out = exp_out + 32'd4;
      end
      kept = kept + (rq ? 1 : 0) - (pop ? 1 : 0);
      if (kept > kept_max) kept_max = kept;
    end
    cyc++;
    redirect_valid = 1'b0;
    drive_next();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    out_ready = 1'b0;
    mq_addr.delete(); mq_due.delete();
    req_got.delete(); req_exp.delete();
    pop_pc.delete(); pop_instr.delete(); pop_exp.delete();
    exp_req = RESET_PC; exp_out = RESET_PC;
    kept = 0; kept_max = 0; redir_req_cnt = 0; cyc = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_next();
  endtask

  task automatic test_reset();
    ready_mode = 0; oready_mode = 1; lat = 1;
    #3 rst_n = 1'b0;
    #1;
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
    total++; if (imem_req_addr !== RESET_PC) begin bad++; $display("FAIL reset_req_addr: got %h want %h", imem_req_addr, RESET_PC); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL reset_out_instr: got %h want 0", out_instr); end
    total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL reset_out_pc: got %h want 0", out_pc); end
    do_reset();
    step();
    total++; if (s_req_valid !== 1'b1 || s_req_addr !== RESET_PC) begin bad++; $display("FAIL reset_first_req: got v=%b a=%h want v=1 a=%h", s_req_valid, s_req_addr, RESET_PC); end
  endtask

  task automatic test_stream();
    ready_mode = 0; oready_mode = 1; lat = 1;
    do_reset();
    repeat (40) step();
    total++; if (pop_pc.size() != 38) begin bad++; $display("FAIL stream_throughput: got %0d pops want 38", pop_pc.size()); end
    foreach (req_got[i]) begin
      total++; if (req_got[i] !== req_exp[i]) begin bad++; $display("FAIL stream_req[%0d]: got %h want %h", i, req_got[i], req_exp[i]); end
    end
    foreach (pop_pc[i]) begin
      total++; if (pop_pc[i] !== pop_exp[i] || pop_instr[i] !== memf(pop_exp[i])) begin
        bad++; $display("FAIL stream_out[%0d]: got pc=%h instr=%h want pc=%h instr=%h", i, pop_pc[i], pop_instr[i], pop_exp[i], memf(pop_exp[i]));
      end
    end
  endtask

  task automatic test_backpressure();
    ready_mode = 0; oready_mode = 0; lat = 3;
    do_reset();
    repeat (20) step();
    total++; if (req_got.size() != DEPTH) begin bad++; $display("FAIL bp_req_count: got %0d want %0d", req_got.size(), DEPTH); end
    total++; if (s_req_valid !== 1'b0) begin bad++; $display("FAIL bp_req_valid_full: got %b want 0", s_req_valid); end
    total++; if (out_valid !== 1'b1 || out_pc !== RESET_PC) begin bad++; $display("FAIL bp_head: got v=%b pc=%h want v=1 pc=%h", out_valid, out_pc, RESET_PC); end
    oready_mode = 1; out_ready = 1'b1;
    step();
    total++; if (s_req_valid !== 1'b0) begin bad++; $display("FAIL bp_req_valid_popcycle: got %b want 0", s_req_valid); end
    step();
    total++; if (s_req_valid !== 1'b1) begin bad++; $display("FAIL bp_req_valid_after_pop: got %b want 1", s_req_valid); end
    repeat (30) step();
    total++; if (kept_max > DEPTH) begin bad++; $display("FAIL bp_occupancy: got %0d want <= %0d", kept_max, DEPTH); end
    total++; if (pop_pc.size() < 8) begin bad++; $display("FAIL bp_drain: got %0d pops want >= 8", pop_pc.size()); end
    foreach (pop_pc[i]) begin
      total++; if (pop_pc[i] !== pop_exp[i] || pop_instr[i] !== memf(pop_exp[i])) begin
        bad++; $display("FAIL bp_out[%0d]: got pc=%h instr=%h want pc=%h", i, pop_pc[i], pop_instr[i], pop_exp[i]);
      end
    end
  endtask

  task automatic test_redirect();
    int idx;
    int n;
    ready_mode = 0; oready_mode = 1; lat = 3;
    do_reset();
    n = 0;
    while (mq_addr.size() != 3 && n < 50) begin step(); n++; end
    total++; if (mq_addr.size() != 3) begin bad++; $display("FAIL redir_setup: got %0d outstanding want 3", mq_addr.size()); end
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    idx = pop_pc.size();
    step();
    total++; if (s_req_valid !== 1'b0) begin bad++; $display("FAIL redir_no_req: got %b want 0", s_req_valid); end
    step();
    total++; if (s_out_valid !== 1'b0) begin bad++; $display("FAIL redir_out_valid: got %b want 0", s_out_valid); end
    total++; if (s_req_valid !== 1'b1 || s_req_addr !== 32'h40) begin bad++; $display("FAIL redir_new_req: got v=%b a=%h want v=1 a=00000040", s_req_valid, s_req_addr); end
    repeat (30) step();
    total++; if (pop_pc.size() <= idx || pop_pc[idx] !== 32'h40 || pop_instr[idx] !== memf(32'h40)) begin
      bad++; $display("FAIL redir_first_out: got %0d pops, want pc=00000040 instr=%h", pop_pc.size(), memf(32'h40));
    end
    foreach (pop_pc[i]) begin
      total++; if (pop_pc[i] !== pop_exp[i] || pop_instr[i] !== memf(pop_exp[i])) begin
        bad++; $display("FAIL redir_out[%0d]: got pc=%h instr=%h want pc=%h", i, pop_pc[i], pop_instr[i], pop_exp[i]);
      end
    end
  endtask

  task automatic test_redirect_collide();
    int idx;
    int n;
    ready_mode = 0; oready_mode = 1; lat = 2;
    do_reset();
    n = 0;
    while (!(imem_rsp_valid && out_valid && out_ready) && n < 50) begin step(); n++; end
    total++; if (!(imem_rsp_valid && out_valid && out_ready)) begin bad++; $display("FAIL collide_setup: no rsp+pop cycle within %0d cycles", n); end
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    idx = pop_pc.size();
    step();
    step();
    total++; if (s_out_valid !== 1'b0) begin bad++; $display("FAIL collide_flush: got out_valid=%b want 0", s_out_valid); end
    repeat (30) step();
    total++; if (pop_pc.size() <= idx || pop_pc[idx] !== 32'h200 || pop_instr[idx] !== memf(32'h200)) begin
      bad++; $display("FAIL collide_first_out: got %0d pops, want pc=00000200 instr=%h", pop_pc.size(), memf(32'h200));
    end
    foreach (pop_pc[i]) begin
      total++; if (pop_pc[i] !== pop_exp[i] || pop_instr[i] !== memf(pop_exp[i])) begin
        bad++; $display("FAIL collide_out[%0d]: got pc=%h instr=%h want pc=%h", i, pop_pc[i], pop_instr[i], pop_exp[i]);
      end
    end
  endtask

  task automatic test_double_redirect();
    int idx;
    ready_mode = 1; oready_mode = 2; lat = 3;
    do_reset();
    repeat (12) step();
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    step();
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    idx = pop_pc.size();
    step();
    repeat (60) step();
    total++; if (pop_pc.size() <= idx || pop_pc[idx] !== 32'h100) begin bad++; $display("FAIL dbl_first_out: got %0d pops, want first pc=00000100", pop_pc.size()); end
    for (int i = idx; i < pop_pc.size(); i++) begin
      total++; if (pop_pc[i] >= 32'h80 && pop_pc[i] < 32'h100) begin bad++; $display("FAIL dbl_leak[%0d]: got pc=%h want >= 00000100", i, pop_pc[i]); end
    end
    foreach (pop_pc[i]) begin
      total++; if (pop_pc[i] !== pop_exp[i] || pop_instr[i] !== memf(pop_exp[i])) begin
        bad++; $display("FAIL dbl_out[%0d]: got pc=%h instr=%h want pc=%h", i, pop_pc[i], pop_instr[i], pop_exp[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] tgt;
    for (int r = 0; r < 6; r++) begin
      ready_mode = 1; oready_mode = 2; lat = int'($urandom_range(1, 6));
      do_reset();
      for (int c = 0; c < 300; c++) begin
        if ($urandom_range(0, 99) < 3) begin
          tgt = $urandom();
          tgt[1:0] = 2'b00;
          redirect_valid = 1'b1;
          redirect_pc = tgt;
        end
        step();
      end
      total++; if (redir_req_cnt != 0) begin bad++; $display("FAIL rnd%0d_req_on_redirect: got %0d want 0", r, redir_req_cnt); end
      total++; if (kept_max > DEPTH) begin bad++; $display("FAIL rnd%0d_occupancy: got %0d want <= %0d", r, kept_max, DEPTH); end
      total++; if (pop_pc.size() < 20) begin bad++; $display("FAIL rnd%0d_progress: got %0d pops want >= 20", r, pop_pc.size()); end
      foreach (req_got[i]) begin
        total++; if (req_got[i] !== req_exp[i]) begin bad++; $display("FAIL rnd%0d_req[%0d]: got %h want %h", r, i, req_got[i], req_exp[i]); end
      end
      foreach (pop_pc[i]) begin
        total++; if (pop_pc[i] !== pop_exp[i] || pop_instr[i] !== memf(pop_exp[i])) begin
          bad++; $display("FAIL rnd%0d_out[%0d]: got pc=%h instr=%h want pc=%h instr=%h", r, i, pop_pc[i], pop_instr[i], pop_exp[i], memf(pop_exp[i]));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    ready_mode = 0; oready_mode = 0; lat = 1;
    do_reset();
    repeat (12) step();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL areset_full: got out_valid=%b want 1", out_valid); end
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL areset_out_valid: got %b want 0", out_valid); end
    total++; if (imem_req_valid !== 1'b0 || imem_req_addr !== RESET_PC) begin bad++; $display("FAIL areset_req: got v=%b a=%h want v=0 a=%h", imem_req_valid, imem_req_addr, RESET_PC); end
    oready_mode = 1;
    do_reset();
    step();
    total++; if (s_req_valid !== 1'b1 || s_req_addr !== RESET_PC) begin bad++; $display("FAIL areset_restart: got v=%b a=%h want v=1 a=%h", s_req_valid, s_req_addr, RESET_PC); end
    repeat (20) step();
    total++; if (pop_pc.size() == 0 || pop_pc[0] !== RESET_PC) begin bad++; $display("FAIL areset_first_out: got %0d pops, want first pc=%h", pop_pc.size(), RESET_PC); end
    foreach (pop_pc[i]) begin
      total++; if (pop_pc[i] !== pop_exp[i] || pop_instr[i] !== memf(pop_exp[i])) begin
        bad++; $display("FAIL areset_out[%0d]: got pc=%h instr=%h want pc=%h", i, pop_pc[i], pop_instr[i], pop_exp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_collide();
    test_double_redirect();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
